serial_change_filter: RTL and testbench

Parametrised serial word filter: receives framed words on a single-bit serial line, compares each word with the last word forwarded, and retransmits it serially only when it has changed or a configurable duplicate limit is reached. It is the generalised successor of the fixed 8-bit serial change-detector used in the benchmark netlist set. It adds:
- configurable word width
- forced periodic retransmission
- a saturating drop counter and an output framing strobe
- optional parity

It sits between a serial source and a serial sink in the same netlist test suite.

---
 rtl/serial_change_filter.sv | 144 ++++++++++++++
 tb/tb_serial_change_filter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/serial_change_filter.sv
// Serial word filter: forwards a framed word only when changed or after HOLD_MAX duplicates; output starts L+1 cycles after the input start bit, no backpressure.
// Optional even parity in and out is enabled by defining SCF_PARITY_EN.
module serial_change_filter #(
    parameter int WIDTH    = 8,
    parameter int HOLD_MAX = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       x,
    output logic       y,
    output logic       y_frame,
    output logic       busy,
    output logic [7:0] drop_count,
    output logic       parity_err
);

`ifdef SCF_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    // N = bits following the start bit (data plus optional parity)
    localparam int N = WIDTH + PB;

    typedef enum logic [1:0] {IDLE, RECV, DECIDE} rx_state_t;
    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

    rx_state_t        rx_state;
    tx_state_t        tx_state;
    logic [N-1:0]     rx_shift;
    logic [N-1:0]     rx_next;
    logic [N-1:0]     tx_shift;
    logic [N-1:0]     tx_word;
    logic [5:0]       rx_cnt;
    logic [5:0]       tx_cnt;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] last_word;
    logic [7:0]       dup_cnt;
    logic             first;
    logic             discard;
    logic             forward;
    logic             load;

    assign rx_next = {x, rx_shift[N-1:1]};
    assign word    = rx_shift[WIDTH-1:0];
    assign forward = first || (word != last_word) ||
                     ((HOLD_MAX != 0) && (dup_cnt == 8'(HOLD_MAX)));
    assign load    = (rx_state == DECIDE) && !discard && forward;
    assign busy    = (rx_state != IDLE) || (tx_state != TX_IDLE);

`ifdef SCF_PARITY_EN
    logic rx_bad;
    assign parity_err = rx_bad;
    assign discard    = rx_bad;
    assign tx_word    = {^word, word};

    // Flag is raised as the last frame bit is taken, so it is high exactly during DECIDE
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_bad <= 1'b0;
        end else begin
            rx_bad <= (rx_state == RECV) && (rx_cnt == 6'(N - 1)) && (^rx_next);
        end
    end
`else
    assign parity_err = 1'b0;
    assign discard    = 1'b0;
    assign tx_word    = word;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_state   <= IDLE;
            rx_shift   <= '0;
            rx_cnt     <= '0;
            last_word  <= '0;
            dup_cnt    <= '0;
            first      <= 1'b1;
            drop_count <= '0;
        end else begin
            case (rx_state)
                IDLE: begin
                    if (x) begin
                        rx_state <= RECV;
                        rx_cnt   <= '0;
                    end
                end
                RECV: begin
                    rx_shift <= rx_next;
                    rx_cnt   <= rx_cnt + 6'd1;
                    if (rx_cnt == 6'(N - 1)) begin
                        rx_state <= DECIDE;
                    end
                end
                DECIDE: begin
                    rx_state <= IDLE;
                    if (!discard) begin
                        if (forward) begin
                            last_word <= word;
                            dup_cnt   <= '0;
                            first     <= 1'b0;
                        end else begin
                            if (dup_cnt < 8'(HOLD_MAX)) begin
                                dup_cnt <= dup_cnt + 8'd1;
                            end
                            if (drop_count != 8'hFF) begin
                                drop_count <= drop_count + 8'd1;
                            end
                        end
                    end
                end
                default: rx_state <= IDLE;
            endcase
        end
    end

    // Start bit goes out on load; tx_cnt then counts the remaining data/parity bits
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_shift <= '0;
            tx_cnt   <= '0;
            y        <= 1'b0;
            y_frame  <= 1'b0;
        end else if (load) begin
            tx_state <= TX_SEND;
            tx_shift <= tx_word;
            tx_cnt   <= 6'(N);
            y        <= 1'b1;
            y_frame  <= 1'b1;
        end else if (tx_state == TX_SEND) begin
            if (tx_cnt != 6'd0) begin
                y        <= tx_shift[0];
                tx_shift <= tx_shift >> 1;
                tx_cnt   <= tx_cnt - 6'd1;
            end else begin
                tx_state <= TX_IDLE;
                y        <= 1'b0;
                y_frame  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_change_filter.sv
// Bench for serial_change_filter: per-word forwarding rules model predicting every output cycle.
module tb_serial_change_filter;
    localparam int W    = 8;
    localparam int HM   = 4;
`ifdef SCF_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int L    = W + 1 + PB;
    localparam int MAXC = 4000;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       x     = 1'b0;
    logic       y;
    logic       y_frame;
    logic       busy;
    logic [7:0] drop_count;
    logic       parity_err;

    serial_change_filter #(.WIDTH(W), .HOLD_MAX(HM)) dut (
        .clock      (clock),
        .reset      (reset),
        .x          (x),
        .y          (y),
        .y_frame    (y_frame),
        .busy       (busy),
        .drop_count (drop_count),
        .parity_err (parity_err)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    bit mon_on = 1'b0;

    // Expected DUT outputs, indexed by cycle number
    bit exp_y  [MAXC];
    bit exp_f  [MAXC];
    bit exp_b  [MAXC];
    bit exp_pe [MAXC];
    int exp_dc [MAXC];

    // Reference state: what the filter has seen so far
    bit         m_first = 1'b1;
    logic [W-1:0] m_last = '0;
    int         m_dup   = 0;
    int         m_drops = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, want);
        end
    endtask

    always @(negedge clock) begin
        if (mon_on && cyc < MAXC) begin
            chk("y", y, exp_y[cyc]);
            chk("y_frame", y_frame, exp_f[cyc]);
            chk("busy", busy, exp_b[cyc]);
            chk("parity_err", parity_err, exp_pe[cyc]);
            chk("drop_count", drop_count, exp_dc[cyc]);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit bad_par, input int gap);
        int t;
        bit fwd;
        logic [L-1:0] fr;
        t  = cyc;
        fr = '0;
        fr[0] = 1'b1;
        for (int i = 0; i < W; i++) fr[1+i] = w[i];
        if (PB == 1) fr[L-1] = (^w) ^ bad_par;
        if (t + 2 * L + 2 < MAXC) begin
            for (int c = t + 1; c <= t + L; c++) exp_b[c] = 1'b1;
            if (PB == 1 && bad_par) begin
                exp_pe[t+L] = 1'b1;
            end else begin
                fwd = m_first || (w != m_last) || (HM != 0 && m_dup == HM);
                if (fwd) begin
                    m_first = 1'b0;
                    m_last  = w;
                    m_dup   = 0;
                    for (int i = 0; i < L; i++) begin
                        exp_y[t+L+1+i] = fr[i];
                        exp_f[t+L+1+i] = 1'b1;
                        exp_b[t+L+1+i] = 1'b1;
                    end
                end else begin
                    if (m_dup < HM) m_dup++;
                    if (m_drops < 255) m_drops++;
                    for (int c = t + L + 1; c < MAXC; c++) exp_dc[c] = m_drops;
                end
            end
        end
        for (int i = 0; i < L; i++) begin
            x = fr[i];
            tick();
        end
        x = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        x     = 1'b0;
        for (int c = cyc; c < MAXC; c++) begin
            exp_y[c]  = 1'b0;
            exp_f[c]  = 1'b0;
            exp_b[c]  = 1'b0;
            exp_pe[c] = 1'b0;
            exp_dc[c] = 0;
        end
        m_first = 1'b1;
        m_last  = '0;
        m_dup   = 0;
        m_drops = 0;
        #1;
        chk("rst_y_now", y, 1'b0);
        chk("rst_frame_now", y_frame, 1'b0);
        chk("rst_busy_now", busy, 1'b0);
        repeat (2) tick();
        reset = 1'b0;
    endtask

    logic [W-1:0] pool [4];

    initial begin
        reset = 1'b1;
        x     = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        chk("reset_drop", drop_count, 0);
        chk("reset_y", y, 0);
        mon_on = 1'b1;
        tick();

        send_word(8'h00, 1'b0, 3);
        send_word(8'h5A, 1'b0, 1);
        send_word(8'h5A, 1'b0, 12);
        repeat (7) send_word(8'h3C, 1'b0, 1);
        send_word(8'h11, 1'b0, 1);
        send_word(8'h22, 1'b0, 1);
        send_word(8'h11, 1'b0, 12);

        // Reset while 0xA5 is mid-transmission, then the same word is first again
        send_word(8'hA5, 1'b0, 4);
        do_reset();
        tick();
        send_word(8'hA5, 1'b0, 12);

        if (PB == 1) begin
            send_word(8'h07, 1'b1, 2);
            send_word(8'h07, 1'b0, 12);
        end

        pool[0] = 8'h3C;
        pool[1] = 8'hC3;
        pool[2] = 8'h00;
        pool[3] = 8'hFF;
        for (int n = 0; n < 50; n++) begin
            logic [W-1:0] w;
            bit bp;
            if ($urandom_range(0, 4) == 0) w = W'($urandom);
            else w = pool[$urandom_range(0, 1 + (n % 3))];
            bp = (PB == 1) && ($urandom_range(0, 5) == 0);
            send_word(w, bp, $urandom_range(1, 3));
        end

        repeat (2 * L + 4) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
